// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage.
// Contents: ALU operation encoding, memory-stage opcode constants,
// divider FSM state type and small helper functions.
package exec_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17,
        ALU_PASS_B = 5'd18
    } alu_op_e;

    localparam logic [6:0] OP_NONE  = 7'd0;
    localparam logic [6:0] OP_LOAD  = 7'd1;
    localparam logic [6:0] OP_STORE = 7'd2;
    localparam logic [6:0] OP_REG   = 7'd3;
    localparam logic [6:0] OP_ECALL = 7'd4;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/pipeline_execute_if.sv
// Decode -> execute -> memory bundle for the execute stage.
// slave  : the execute stage (takes the decode request and mem_ready,
//          drives in_ready, the EX/MEM register outputs and busy).
// master : the surrounding pipeline / testbench side.
interface pipeline_execute_if;
    import exec_pkg::*;

    logic          in_valid;
    logic          in_ready;
    alu_op_e       alu_op;
    logic [63:0]   op_a;
    logic [63:0]   op_b;
    logic [63:0]   r2_val;
    logic [4:0]    dst_reg;
    logic [6:0]    opcode;
    logic [3:0]    mem_operation_size;
    logic          word_op;
    logic          ecall;
    logic          mem_ready;

    logic [63:0]   ex_res;
    logic [63:0]   ex_r2_val;
    logic [4:0]    ex_dst_reg;
    logic [6:0]    ex_opcode;
    logic [3:0]    ex_mem_size;
    logic          ex_ecall;
    logic          busy;

    modport slave (
        input  in_valid, alu_op, op_a, op_b, r2_val, dst_reg, opcode,
               mem_operation_size, word_op, ecall, mem_ready,
        output in_ready, ex_res, ex_r2_val, ex_dst_reg, ex_opcode,
               ex_mem_size, ex_ecall, busy
    );

    modport master (
        output in_valid, alu_op, op_a, op_b, r2_val, dst_reg, opcode,
               mem_operation_size, word_op, ecall, mem_ready,
        input  in_ready, ex_res, ex_r2_val, ex_dst_reg, ex_opcode,
               ex_mem_size, ex_ecall, busy
    );

endinterface

// File: rtl/exec_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Ports: clk/reset (sync, active-high); start launches a divide from IDLE;
// is_signed/want_rem/word_op select the flavour; dividend/divisor are
// sampled at start; ack retires a finished result; busy is high while
// running or holding a result; done flags a valid result.
module exec_divider
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic        want_rem,
    input  logic        word_op,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    div_state_e  state;
    logic [6:0]  count;
    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dvs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        want_rem_q;
    logic        word_q;
    logic        special_q;
    logic [63:0] special_res_q;

    // Operand preparation at acceptance
    logic [63:0] a_val, b_val, a_mag, b_mag, special_res;
    logic        a_neg, b_neg, div_zero, overflow;

    always_comb begin
        if (word_op) begin
            a_val = is_signed ? sext32(dividend[31:0]) : {32'b0, dividend[31:0]};
            b_val = is_signed ? sext32(divisor[31:0])  : {32'b0, divisor[31:0]};
        end else begin
            a_val = dividend;
            b_val = divisor;
        end
        a_neg    = is_signed & a_val[63];
        b_neg    = is_signed & b_val[63];
        a_mag    = a_neg ? ('0 - a_val) : a_val;
        b_mag    = b_neg ? ('0 - b_val) : b_val;
        div_zero = (b_val == '0);
        overflow = is_signed && (b_val == '1) &&
                   (a_val == (word_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        if (div_zero)
            special_res = want_rem ? a_val : '1;
        else
            special_res = want_rem ? '0 : a_val;
    end

    // One restoring step; trial[64] set means trial already exceeds any 64-bit divisor
    logic [64:0] trial;
    logic        ge;
    always_comb begin
        trial = {rem_q, quo_q[63]};
        ge    = trial[64] | (trial[63:0] >= dvs_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= DIV_IDLE;
            count         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            want_rem_q    <= 1'b0;
            word_q        <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state         <= DIV_RUN;
                        count         <= word_op ? 7'd32 : 7'd64;
                        rem_q         <= '0;
                        // Word divides start with the 32-bit dividend in the top half
                        quo_q         <= word_op ? {a_mag[31:0], 32'b0} : a_mag;
                        dvs_q         <= b_mag;
                        q_neg_q       <= a_neg ^ b_neg;
                        r_neg_q       <= a_neg;
                        want_rem_q    <= want_rem;
                        word_q        <= word_op;
                        special_q     <= div_zero | overflow;
                        special_res_q <= special_res;
                    end
                end
                DIV_RUN: begin
                    rem_q <= ge ? (trial[63:0] - dvs_q) : trial[63:0];
                    quo_q <= {quo_q[62:0], ge};
                    count <= count - 7'd1;
                    if (count == 7'd1)
                        state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (ack)
                        state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    logic [63:0] mag, signed_res, raw;
    always_comb begin
        if (want_rem_q)
            mag = rem_q;
        else
            mag = word_q ? {32'b0, quo_q[31:0]} : quo_q;
        signed_res = (want_rem_q ? r_neg_q : q_neg_q) ? ('0 - mag) : mag;
        raw        = special_q ? special_res_q : signed_res;
        result     = word_q ? sext32(raw[31:0]) : raw;
    end

    assign busy = (state != DIV_IDLE);
    assign done = (state == DIV_DONE);

endmodule

// File: rtl/pipeline_execute.sv
// Execute stage of the in-order RV64 pipeline.
// Ports: clk, reset (sync, active-high) and bus (pipeline_execute_if.slave)
// carrying the decode request (in_valid/in_ready, alu_op, operands,
// metadata), mem_ready from the memory stage, the EX/MEM register outputs
// (ex_*) and busy (divider active).
// ALU and multiplier are single-cycle; divide/remainder go through
// exec_divider and occupy the stage until retired into EX/MEM.
module pipeline_execute
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input logic               clk,
    input logic               reset,
    pipeline_execute_if.slave bus
);

    logic is_mem, is_div, div_busy, div_done, div_start, cap_alu;
    logic [DATA_WIDTH-1:0] div_result;

    assign is_mem    = (bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE);
    assign is_div    = is_div_op(bus.alu_op) && !is_mem;
    assign div_start = bus.in_valid & is_div & ~div_busy;
    assign cap_alu   = bus.in_valid & ~is_div & ~div_busy;

    // Divides are accepted without waiting for the memory stage
    assign bus.in_ready = reset    ? 1'b0 :
                          div_busy ? 1'b0 :
                          is_div   ? 1'b1 : bus.mem_ready;

    // Combinational ALU / multiplier
    logic [5:0]             sh;
    logic [127:0]           mul_a, mul_b, prod;
    logic                   mul_sa, mul_sb;
    logic [31:0]            sraw;
    logic [DATA_WIDTH-1:0]  r, alu_res;

    always_comb begin
        sh     = bus.word_op ? {1'b0, bus.op_b[4:0]} : bus.op_b[5:0];
        mul_sa = (bus.alu_op == ALU_MULH) || (bus.alu_op == ALU_MULHSU);
        mul_sb = (bus.alu_op == ALU_MULH);
        // Extending to 128 bits lets one unsigned multiplier serve every MUL* variant
        mul_a  = {{64{mul_sa & bus.op_a[63]}}, bus.op_a};
        mul_b  = {{64{mul_sb & bus.op_b[63]}}, bus.op_b};
        prod   = mul_a * mul_b;
        sraw   = $signed(bus.op_a[31:0]) >>> sh[4:0];

        case (bus.alu_op)
            ALU_ADD:    r = bus.op_a + bus.op_b;
            ALU_SUB:    r = bus.op_a - bus.op_b;
            ALU_SLL:    r = bus.op_a << sh;
            ALU_SLT:    r = {63'b0, $signed(bus.op_a) < $signed(bus.op_b)};
            ALU_SLTU:   r = {63'b0, bus.op_a < bus.op_b};
            ALU_XOR:    r = bus.op_a ^ bus.op_b;
            ALU_SRL:    r = bus.word_op ? {32'b0, bus.op_a[31:0] >> sh[4:0]} : (bus.op_a >> sh);
            ALU_SRA:    r = bus.word_op ? {32'b0, sraw} : ($signed(bus.op_a) >>> sh);
            ALU_OR:     r = bus.op_a | bus.op_b;
            ALU_AND:    r = bus.op_a & bus.op_b;
            ALU_MUL:    r = prod[63:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  r = prod[127:64];
            ALU_PASS_B: r = bus.op_b;
            default:    r = '0;
        endcase

        if (is_mem)
            alu_res = bus.op_a + bus.op_b;
        else if (bus.word_op)
            alu_res = sext32(r[31:0]);
        else
            alu_res = r;
    end

    exec_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .is_signed ((bus.alu_op == ALU_DIV) || (bus.alu_op == ALU_REM)),
        .want_rem  ((bus.alu_op == ALU_REM) || (bus.alu_op == ALU_REMU)),
        .word_op   (bus.word_op),
        .dividend  (bus.op_a),
        .divisor   (bus.op_b),
        .ack       (bus.mem_ready),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    // Metadata of the in-flight divide, replayed into EX/MEM on retirement
    logic [63:0] d_r2_val;
    logic [4:0]  d_dst_reg;
    logic [6:0]  d_opcode;
    logic [3:0]  d_mem_size;
    logic        d_ecall;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_r2_val   <= '0;
            d_dst_reg  <= '0;
            d_opcode   <= '0;
            d_mem_size <= '0;
            d_ecall    <= 1'b0;
        end else if (div_start) begin
            d_r2_val   <= bus.r2_val;
            d_dst_reg  <= bus.dst_reg;
            d_opcode   <= bus.opcode;
            d_mem_size <= bus.mem_operation_size;
            d_ecall    <= bus.ecall;
        end
    end

    // EX/MEM pipeline register
    logic [63:0] ex_res_q, ex_r2_val_q;
    logic [4:0]  ex_dst_reg_q;
    logic [6:0]  ex_opcode_q;
    logic [3:0]  ex_mem_size_q;
    logic        ex_ecall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_res_q      <= '0;
            ex_r2_val_q   <= '0;
            ex_dst_reg_q  <= '0;
            ex_opcode_q   <= OP_NONE;
            ex_mem_size_q <= '0;
            ex_ecall_q    <= 1'b0;
        end else if (bus.mem_ready) begin
            if (div_done) begin
                ex_res_q      <= div_result;
                ex_r2_val_q   <= d_r2_val;
                ex_dst_reg_q  <= d_dst_reg;
                ex_opcode_q   <= d_opcode;
                ex_mem_size_q <= d_mem_size;
                ex_ecall_q    <= d_ecall;
            end else if (cap_alu) begin
                ex_res_q      <= alu_res;
                ex_r2_val_q   <= bus.r2_val;
                ex_dst_reg_q  <= bus.dst_reg;
                ex_opcode_q   <= bus.opcode;
                ex_mem_size_q <= bus.mem_operation_size;
                ex_ecall_q    <= bus.ecall;
            end else begin
                ex_res_q      <= '0;
                ex_r2_val_q   <= '0;
                ex_dst_reg_q  <= '0;
                ex_opcode_q   <= OP_NONE;
                ex_mem_size_q <= '0;
                ex_ecall_q    <= 1'b0;
            end
        end
    end

    assign bus.ex_res      = ex_res_q;
    assign bus.ex_r2_val   = ex_r2_val_q;
    assign bus.ex_dst_reg  = ex_dst_reg_q;
    assign bus.ex_opcode   = ex_opcode_q;
    assign bus.ex_mem_size = ex_mem_size_q;
    assign bus.ex_ecall    = ex_ecall_q;
    assign bus.busy        = div_busy;

endmodule

// File: tb/tb_pipeline_execute.sv
// Directed testbench for pipeline_execute with hand-computed expectations.
module tb_pipeline_execute;
    import exec_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipeline_execute_if bus ();

    pipeline_execute #(.DATA_WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                         input logic w, input logic [6:0] opc, input logic [4:0] dst,
                         input logic [3:0] size, input logic [63:0] r2);
        bus.in_valid           = 1'b1;
        bus.alu_op             = op;
        bus.op_a               = a;
        bus.op_b               = b;
        bus.word_op            = w;
        bus.opcode             = opc;
        bus.dst_reg            = dst;
        bus.mem_operation_size = size;
        bus.r2_val             = r2;
        bus.ecall              = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_step(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                            input logic w, input logic [63:0] exp, input string tag);
        drive(op, a, b, w, OP_REG, 5'd1, 4'd0, 64'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk(tag, bus.ex_res, exp);
    endtask

    task automatic div_step(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                            input logic w, input logic [63:0] exp, input int lat,
                            input string tag);
        int n;
        drive(op, a, b, w, OP_REG, 5'd7, 4'd0, 64'd0);
        bus.mem_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, {63'b0, bus.in_ready}, 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, {63'b0, bus.busy}, 64'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ex_opcode !== OP_REG && n < 200);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, bus.ex_res, exp);
        chk({tag, "_idle"}, {63'b0, bus.busy}, 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(ALU_ADD, 64'd1, 64'd1, 1'b0, OP_REG, 5'd3, 4'd0, 64'd0);
        bus.mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
        chk("rst_opcode", {57'b0, bus.ex_opcode}, 64'd0);
        chk("rst_res", bus.ex_res, 64'd0);
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        reset = 1'b0;

        // ADD 5 + 7 -> 12, one cycle
        drive(ALU_ADD, 64'd5, 64'd7, 1'b0, OP_REG, 5'd10, 4'd0, 64'd0);
        #1;
        chk("add_ready", {63'b0, bus.in_ready}, 64'd1);
        tick();
        chk("add_res", bus.ex_res, 64'd12);
        chk("add_opc", {57'b0, bus.ex_opcode}, 64'd3);
        chk("add_dst", {59'b0, bus.ex_dst_reg}, 64'd10);

        // Load effective address
        drive(ALU_ADD, 64'h1000, 64'h20, 1'b0, OP_LOAD, 5'd4, 4'd2, 64'd0);
        tick();
        chk("ld_res", bus.ex_res, 64'h1020);
        chk("ld_size", {60'b0, bus.ex_mem_size}, 64'd2);
        chk("ld_opc", {57'b0, bus.ex_opcode}, 64'd1);

        // Store with data pass-through
        drive(ALU_ADD, 64'h2000, 64'h8, 1'b0, OP_STORE, 5'd0, 4'd3, 64'hDEAD_BEEF);
        tick();
        chk("st_res", bus.ex_res, 64'h2008);
        chk("st_r2", bus.ex_r2_val, 64'hDEAD_BEEF);

        // SUB held off by mem_ready for three cycles
        drive(ALU_SUB, 64'd20, 64'd3, 1'b0, OP_REG, 5'd9, 4'd0, 64'd0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", {63'b0, bus.in_ready}, 64'd0);
            tick();
            chk("stall_hold_res", bus.ex_res, 64'h2008);
            chk("stall_hold_opc", {57'b0, bus.ex_opcode}, 64'd2);
        end
        bus.mem_ready = 1'b1;
        tick();
        chk("stall_sub_res", bus.ex_res, 64'd17);

        // ALU corner vectors
        alu_step(ALU_SLL,    64'd1, 64'h41, 1'b0, 64'd2, "sll_6bit");
        alu_step(ALU_SRL,    64'h8000_0000_0000_0000, 64'h3F, 1'b0, 64'd1, "srl_63");
        alu_step(ALU_SRA,    64'h8000_0000, 64'd4, 1'b1, 64'hFFFF_FFFF_F800_0000, "sraw");
        alu_step(ALU_SLT,    64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, "slt");
        alu_step(ALU_SLTU,   64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, "sltu");
        alu_step(ALU_MUL,    64'h1_0000, 64'h1_0000, 1'b0, 64'h1_0000_0000, "mul");
        alu_step(ALU_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFE, "mulhu");
        alu_step(ALU_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
        alu_step(ALU_ADD,    64'h7FFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "addw");
        alu_step(ALU_PASS_B, 64'd7, 64'h1234_5000, 1'b0, 64'h1234_5000, "pass_b");

        // No valid instruction -> bubble
        bus.in_valid = 1'b0;
        tick();
        chk("bubble_opc", {57'b0, bus.ex_opcode}, 64'd0);
        chk("bubble_res", bus.ex_res, 64'd0);

        // Divides
        div_step(ALU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_neg7_2");

        // DIVU by zero accepted while mem_ready=0, then held in DONE
        drive(ALU_DIVU, 64'd9, 64'd0, 1'b0, OP_REG, 5'd8, 4'd0, 64'd0);
        bus.mem_ready = 1'b0;
        #1;
        chk("divu0_ready", {63'b0, bus.in_ready}, 64'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 70; i++) tick();
        chk("divu0_busy_hold", {63'b0, bus.busy}, 64'd1);
        chk("divu0_exmem_hold", bus.ex_res, 64'hFFFF_FFFF_FFFF_FFFD);
        bus.mem_ready = 1'b1;
        tick();
        chk("divu0_res", bus.ex_res, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("divu0_dst", {59'b0, bus.ex_dst_reg}, 64'd8);
        chk("divu0_idle", {63'b0, bus.busy}, 64'd0);

        div_step(ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_neg7_2");
        div_step(ALU_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 64'd0, 65, "rem_ovf");
        div_step(ALU_DIV, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                 64'hFFFF_FFFF_8000_0000, 33, "divw_ovf");

        // Reset during a divide
        drive(ALU_DIVU, 64'd100, 64'd7, 1'b0, OP_REG, 5'd2, 4'd0, 64'd0);
        bus.mem_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("mid_busy", {63'b0, bus.busy}, 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("mid_rst_opc", {57'b0, bus.ex_opcode}, 64'd0);
        chk("mid_rst_res", bus.ex_res, 64'd0);
        reset = 1'b0;
        drive(ALU_ADD, 64'd1, 64'd2, 1'b0, OP_REG, 5'd1, 4'd0, 64'd0);
        bus.mem_ready = 1'b0;
        #1;
        chk("post_rst_ready0", {63'b0, bus.in_ready}, 64'd0);
        bus.mem_ready = 1'b1;
        #1;
        chk("post_rst_ready1", {63'b0, bus.in_ready}, 64'd1);
        tick();
        chk("post_rst_add", bus.ex_res, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
